// File: rtl/serial_adder.sv
// Bit-serial adder/subtractor: one full-adder slice plus a registered carry,
// processing one operand bit per clock, LSB first. The result and flags are
// registered and only change at the completion edge or at reset.
//
// Handshake: Start is sampled on a rising edge while in IDLE or DONE; that
// edge latches A, B, Cin and Sub. Busy is high for exactly WIDTH cycles while
// bits are processed, and Done is a one-cycle pulse marking a fresh result.
// Start seen during ADD is ignored. Holding Start high through DONE starts
// the next operation on the following edge with no idle cycle.
module serial_adder #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             Start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    input  logic             Sub,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout,
    output logic             Overflow,
    output logic             Zero,
    output logic             Busy,
    output logic             Done,
    output logic [1:0]       dbg_state
);

    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;
    logic [WIDTH-1:0] res;
    logic             carry;
    logic [CNT_W-1:0] cnt;

    logic             fa_sum;
    logic             fa_cout;
    logic [WIDTH-1:0] shift_next;

    // Full-adder slice on the current LSBs and the carry flop.
    always_comb begin
        fa_sum     = opa[0] ^ opb[0] ^ carry;
        fa_cout    = (opa[0] & opb[0]) | (carry & (opa[0] ^ opb[0]));
        shift_next = {fa_sum, res[WIDTH-1:1]};
    end

    assign dbg_state = state;

    // Control FSM, operand/result shift registers and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            opa      <= '0;
            opb      <= '0;
            res      <= '0;
            carry    <= 1'b0;
            cnt      <= '0;
            Sum      <= '0;
            Cout     <= 1'b0;
            Overflow <= 1'b0;
            Zero     <= 1'b0;
            Busy     <= 1'b0;
            Done     <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (Start) begin
                        // Subtraction is A + ~B + 1; Cin is ignored.
                        opa   <= A;
                        opb   <= Sub ? ~B : B;
                        carry <= Sub ? 1'b1 : Cin;
                        cnt   <= '0;
                        state <= ADD;
                        Busy  <= 1'b1;
                        Done  <= 1'b0;
                    end else begin
                        state <= IDLE;
                        Busy  <= 1'b0;
                        Done  <= 1'b0;
                    end
                end
                ADD: begin
                    res   <= shift_next;
                    opa   <= opa >> 1;
                    opb   <= opb >> 1;
                    carry <= fa_cout;
                    cnt   <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        // carry currently holds the carry into the MSB slice.
                        Sum      <= shift_next;
                        Cout     <= fa_cout;
                        Overflow <= carry ^ fa_cout;
                        Zero     <= (shift_next == '0);
                        state    <= DONE;
                        Busy     <= 1'b0;
                        Done     <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    Busy  <= 1'b0;
                    Done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder: an 8-bit instance for most scenarios and a 32-bit
// instance for the mid-operation reset case. Expected results are pushed to
// per-instance queues when an operation is launched and popped at Done.
module tb_serial_adder;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // ---------------- 8-bit instance ----------------
    logic        s8, cin8, sub8;
    logic [7:0]  a8, b8, sum8;
    logic        cout8, ovf8, zero8, busy8, done8;
    logic [1:0]  st8;

    serial_adder #(.WIDTH(8)) u8 (
        .clk(clk), .rst_n(rst_n), .Start(s8), .A(a8), .B(b8), .Cin(cin8),
        .Sub(sub8), .Sum(sum8), .Cout(cout8), .Overflow(ovf8), .Zero(zero8),
        .Busy(busy8), .Done(done8), .dbg_state(st8)
    );

    // ---------------- 32-bit instance ----------------
    logic        s32, cin32, sub32;
    logic [31:0] a32, b32, sum32;
    logic        cout32, ovf32, zero32, busy32, done32;
    logic [1:0]  st32;

    serial_adder #(.WIDTH(32)) u32 (
        .clk(clk), .rst_n(rst_n), .Start(s32), .A(a32), .B(b32), .Cin(cin32),
        .Sub(sub32), .Sum(sum32), .Cout(cout32), .Overflow(ovf32), .Zero(zero32),
        .Busy(busy32), .Done(done32), .dbg_state(st32)
    );

    // ---------------- scoreboard ----------------
    // Entry layout: {Cout, Overflow, Zero, Sum}
    logic [10:0] exp8_q[$];
    logic [34:0] exp32_q[$];
    int checks = 0;
    int passed = 0;

    // Independent reference: plain integer arithmetic on w-bit operands.
    function automatic logic [66:0] model(input logic [63:0] a, input logic [63:0] b,
                                          input logic cin, input logic sub, input int w);
        logic [63:0] mask, eb, r, am;
        logic [64:0] s;
        logic        co, ov;
        mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
        am   = a & mask;
        eb   = (sub ? ~b : b) & mask;
        s    = {1'b0, am} + {1'b0, eb} + {64'd0, (sub ? 1'b1 : cin)};
        r    = s[63:0] & mask;
        co   = s[w];
        ov   = (am[w-1] == eb[w-1]) && (r[w-1] != am[w-1]);
        return {co, ov, (r == 64'd0), r};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive8(input logic [7:0] a, input logic [7:0] b,
                          input logic cin, input logic sub);
        a8 = a; b8 = b; cin8 = cin; sub8 = sub; s8 = 1'b1;
        tick();
        s8 = 1'b0;
    endtask

    task automatic drive32(input logic [31:0] a, input logic [31:0] b,
                           input logic cin, input logic sub);
        a32 = a; b32 = b; cin32 = cin; sub32 = sub; s32 = 1'b1;
        tick();
        s32 = 1'b0;
    endtask

    task automatic wait8(output int n);
        n = 0;
        while (done8 !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
    endtask

    task automatic wait32(output int n);
        n = 0;
        while (done32 !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        int pulses;
        int busy_seen;
        rst_n = 1'b0;
        s8 = 0; a8 = 0; b8 = 0; cin8 = 0; sub8 = 0;
        s32 = 0; a32 = 0; b32 = 0; cin32 = 0; sub32 = 0;
        #2;
        checks++;
        if ({sum8, cout8, ovf8, zero8, busy8, done8} !== 13'd0)
            $display("FAIL reset_outputs: got sum=%h c=%b v=%b z=%b busy=%b done=%b want all 0",
                     sum8, cout8, ovf8, zero8, busy8, done8);
        else passed++;
        repeat (3) tick();
        rst_n = 1'b1;
        pulses = 0; busy_seen = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (done8 === 1'b1) pulses++;
            if (busy8 !== 1'b0) busy_seen++;
        end
        checks++;
        if (pulses != 0 || busy_seen != 0)
            $display("FAIL idle_quiet: done pulses %0d busy cycles %0d want 0 and 0", pulses, busy_seen);
        else passed++;
        checks++;
        if ({sum8, cout8, ovf8, zero8} !== 11'd0)
            $display("FAIL idle_outputs: got sum=%h c=%b v=%b z=%b want 00 0 0 0",
                     sum8, cout8, ovf8, zero8);
        else passed++;
    endtask

    task automatic test_overflow();
        int n;
        int busy_bad;
        logic [10:0] e;
        exp8_q.push_back({1'b0, 1'b1, 1'b0, 8'h80});
        drive8(8'h7F, 8'h01, 1'b0, 1'b0);
        busy_bad = 0;
        n = 0;
        while (done8 !== 1'b1 && n < 100) begin
            if (busy8 !== 1'b1) busy_bad++;
            if ({sum8, cout8, ovf8, zero8} !== 11'd0) busy_bad++;
            tick();
            n++;
        end
        checks++;
        if (n != 8) $display("FAIL ovf_latency: got %0d edges after accept want 8", n);
        else passed++;
        checks++;
        if (busy_bad != 0 || busy8 !== 1'b0)
            $display("FAIL ovf_busy: bad busy/held cycles %0d busy_at_done=%b want 0 and 0", busy_bad, busy8);
        else passed++;
        e = exp8_q.pop_front();
        checks++;
        if ({cout8, ovf8, zero8, sum8} !== e)
            $display("FAIL ovf_result: got c=%b v=%b z=%b sum=%h want %h", cout8, ovf8, zero8, sum8, e);
        else passed++;
        tick();
        checks++;
        if (done8 !== 1'b0 || sum8 !== 8'h80)
            $display("FAIL ovf_done_pulse: got done=%b sum=%h want 0 and 80", done8, sum8);
        else passed++;
    endtask

    task automatic test_carry_cin();
        int n;
        logic [10:0] e;
        exp8_q.push_back({1'b1, 1'b0, 1'b1, 8'h00});
        drive8(8'hFF, 8'h00, 1'b1, 1'b0);
        wait8(n);
        e = exp8_q.pop_front();
        checks++;
        if (n != 8 || {cout8, ovf8, zero8, sum8} !== e)
            $display("FAIL carry_cin: got n=%0d c=%b v=%b z=%b sum=%h want n=8 %h",
                     n, cout8, ovf8, zero8, sum8, e);
        else passed++;
    endtask

    task automatic test_back_to_back();
        int n;
        int held_bad;
        logic [10:0] e;
        exp8_q.push_back({1'b0, 1'b0, 1'b0, 8'hFE});
        a8 = 8'h05; b8 = 8'h07; cin8 = 1'b0; sub8 = 1'b1; s8 = 1'b1;
        tick();
        wait8(n);
        e = exp8_q.pop_front();
        checks++;
        if (n != 8 || {cout8, ovf8, zero8, sum8} !== e)
            $display("FAIL sub_first: got n=%0d c=%b v=%b z=%b sum=%h want n=8 %h",
                     n, cout8, ovf8, zero8, sum8, e);
        else passed++;
        // Start still high in DONE: next edge must accept the new operands.
        a8 = 8'h07; b8 = 8'h05;
        exp8_q.push_back({1'b1, 1'b0, 1'b0, 8'h02});
        tick();
        s8 = 1'b0;
        checks++;
        if (busy8 !== 1'b1 || done8 !== 1'b0)
            $display("FAIL b2b_start: got busy=%b done=%b want 1 and 0", busy8, done8);
        else passed++;
        held_bad = 0;
        n = 0;
        while (done8 !== 1'b1 && n < 100) begin
            if (sum8 !== 8'hFE) held_bad++;
            tick();
            n++;
        end
        checks++;
        if (held_bad != 0)
            $display("FAIL b2b_sum_hold: %0d cycles with sum != FE want 0", held_bad);
        else passed++;
        e = exp8_q.pop_front();
        checks++;
        if (n != 8 || {cout8, ovf8, zero8, sum8} !== e)
            $display("FAIL b2b_second: got n=%0d c=%b v=%b z=%b sum=%h want n=8 %h",
                     n, cout8, ovf8, zero8, sum8, e);
        else passed++;
        tick();
    endtask

    task automatic test_busy_ignore();
        int n;
        int pulses;
        logic [10:0] e;
        exp8_q.push_back({1'b0, 1'b0, 1'b0, 8'h30});
        drive8(8'h10, 8'h20, 1'b0, 1'b0);
        repeat (3) tick();
        a8 = 8'hFF; b8 = 8'hFF; s8 = 1'b1;
        tick();
        s8 = 1'b0;
        wait8(n);
        e = exp8_q.pop_front();
        checks++;
        if (n + 4 != 8 || {cout8, ovf8, zero8, sum8} !== e)
            $display("FAIL busy_ignore: got edges=%0d c=%b v=%b z=%b sum=%h want edges=8 %h",
                     n + 4, cout8, ovf8, zero8, sum8, e);
        else passed++;
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (done8 === 1'b1) pulses++;
        end
        checks++;
        if (pulses != 0 || busy8 !== 1'b0)
            $display("FAIL busy_ignore_pulses: extra done %0d busy=%b want 0 and 0", pulses, busy8);
        else passed++;
    endtask

    task automatic test_random();
        int n;
        int bad;
        logic [7:0]  ra, rb;
        logic        rc, rs;
        logic [66:0] m;
        logic [10:0] e;
        bad = 0;
        for (int i = 0; i < 16; i++) begin
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            rc = 1'($urandom_range(0, 1));
            rs = 1'($urandom_range(0, 1));
            m  = model({56'd0, ra}, {56'd0, rb}, rc, rs, 8);
            exp8_q.push_back({m[66], m[65], m[64], m[7:0]});
            drive8(ra, rb, rc, rs);
            wait8(n);
            e = exp8_q.pop_front();
            checks++;
            if (n != 8 || {cout8, ovf8, zero8, sum8} !== e)
                $display("FAIL random_%0d: a=%h b=%h cin=%b sub=%b got n=%0d %h want n=8 %h",
                         i, ra, rb, rc, rs, n, {cout8, ovf8, zero8, sum8}, e);
            else passed++;
            if ($urandom_range(0, 1) == 1) tick();
        end
    endtask

    task automatic test_reset_mid();
        int n;
        int stray;
        logic [34:0] e;
        logic [66:0] m;
        // Complete one op first so the reset has non-zero outputs to clear.
        m = model(64'h12345678, 64'h1, 1'b0, 1'b0, 32);
        exp32_q.push_back({m[66], m[65], m[64], m[31:0]});
        drive32(32'h12345678, 32'h1, 1'b0, 1'b0);
        wait32(n);
        e = exp32_q.pop_front();
        checks++;
        if (n != 32 || {cout32, ovf32, zero32, sum32} !== e)
            $display("FAIL w32_first: got n=%0d %h want n=32 %h", n, {cout32, ovf32, zero32, sum32}, e);
        else passed++;
        tick();
        exp32_q.push_back(35'd0);
        drive32(32'hFFFFFFFF, 32'h1, 1'b0, 1'b0);
        repeat (9) tick();
        rst_n = 1'b0;
        #1;
        exp32_q.delete();
        checks++;
        if ({sum32, cout32, ovf32, zero32, busy32, done32} !== 37'd0)
            $display("FAIL mid_reset_clear: got sum=%h c=%b v=%b z=%b busy=%b done=%b want all 0",
                     sum32, cout32, ovf32, zero32, busy32, done32);
        else passed++;
        tick();
        rst_n = 1'b1;
        stray = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (done32 === 1'b1 || busy32 === 1'b1) stray++;
        end
        checks++;
        if (stray != 0) $display("FAIL mid_reset_stray: %0d busy/done cycles want 0", stray);
        else passed++;
        exp32_q.push_back({1'b0, 1'b0, 1'b0, 32'd7});
        drive32(32'd3, 32'd4, 1'b0, 1'b0);
        wait32(n);
        e = exp32_q.pop_front();
        checks++;
        if (n + 1 != 33 || {cout32, ovf32, zero32, sum32} !== e)
            $display("FAIL mid_reset_restart: got edges=%0d %h want edges=33 %h",
                     n + 1, {cout32, ovf32, zero32, sum32}, e);
        else passed++;
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_overflow();
        test_carry_cin();
        test_back_to_back();
        test_busy_ignore();
        test_random();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Bit-serial adder/subtractor built around one full-adder slice (A, B, Cin in; Sum, Cout out) and a registered carry.
- Consumes WIDTH-bit operands, processes one bit per clock LSB-first, and produces a WIDTH-bit result with Cout, Overflow and Zero flags.
- Sits downstream of the operand registers and feeds the ALU result path, where area matters more than latency.

Parameters:
- WIDTH, 32, operand/result width in bits; legal range 2 to 64.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- Start  input  1  request a new operation; sampled on a rising edge of clk.
- A  input  WIDTH  operand A; sampled only when Start is accepted.
- B  input  WIDTH  operand B; sampled only when Start is accepted.
- Cin  input  1  carry-in; sampled with operands; ignored when Sub=1.
- Sub  input  1  1 = compute A - B; sampled with operands.
- Sum  output  WIDTH  registered result; stable between completions.
- Cout  output  1  final carry out of the MSB slice.
- Overflow  output  1  signed overflow = carry into MSB XOR carry out of MSB.
- Zero  output  1  1 when Sum == 0.
- Busy  output  1  high while bits are being processed.
- Done  output  1  one-cycle pulse when a new result is valid.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
  - rst_n low forces state IDLE immediately, without waiting for a clock edge.
  - It also clears Sum, Cout, Overflow, Zero, Busy, Done, the carry flop, the bit counter and the internal shift registers.
- States: IDLE, ADD, DONE. Moore outputs: Busy=1 only in ADD; Done=1 only in DONE.
- IDLE or DONE, Start=1 at an edge (the accept edge E0):
  - Latch opA=A. Latch opB = Sub ? ~B : B.
  - Carry flop = Sub ? 1 : Cin.
  - Counter = 0; go to ADD.
- IDLE or DONE, Start=0: IDLE stays in IDLE; DONE moves to IDLE.
- ADD, each edge:
  - Full-adder slice takes opA[0], opB[0] and the carry flop.
  - Its sum bit shifts into the MSB of the result shift register, which shifts right. opA and opB also shift right.
  - The carry flop takes the slice Cout; the counter increments.
  - On the edge where counter == WIDTH-1:
    - Capture the carry into the MSB slice.
    - Load Sum from the completed shift value, Cout from the slice Cout, Overflow and Zero.
    - Go to DONE.
- Start while in ADD: ignored; the operation in flight continues unchanged.
- Latency:
  - The accept edge E0 is followed by WIDTH processing edges E1..EWIDTH.
  - Done is high in the cycle after EWIDTH and Busy is low in that cycle.
  - Total: WIDTH+1 edges from accept to Done.
- Back-to-back: Start held high in DONE is accepted on the following edge, so a new operation starts with no idle cycle. Done stays high for exactly one cycle.
- Output stability: Sum, Cout, Overflow and Zero change only at the completion edge or at reset. They hold during ADD, IDLE and the DONE cycle.
- Subtraction: the result is two's-complement A-B. Cout=1 means no borrow (A >= B unsigned).
- Wrap-around: the result is modulo 2^WIDTH; the carry is reported only via Cout.
- Reset mid-operation: a partial result is discarded. Outputs read zero, Zero reads 0 (it is cleared, not computed), and the next Start begins cleanly.
- Operand changes on A, B, Cin and Sub after the accept edge have no effect on the operation in flight.

Test Plan:
- Reset then idle (WIDTH=8): hold rst_n=0, release, no Start for 20 cycles -> Sum=0x00, Cout=0, Overflow=0, Zero=0, Busy=0, Done never pulses.
- Signed overflow (WIDTH=8): A=0x7F, B=0x01, Cin=0, Sub=0, Start one cycle -> Busy high 8 cycles; Done pulses on cycle 9 after the accept edge; Sum=0x80, Cout=0, Overflow=1, Zero=0.
- Full carry with Cin (WIDTH=8): A=0xFF, B=0x00, Cin=1 -> Sum=0x00, Cout=1, Overflow=0, Zero=1.
- Subtract, then back-to-back (WIDTH=8):
  - First op A=0x05, B=0x07, Sub=1 -> Sum=0xFE, Cout=0, Overflow=0.
  - Hold Start high through Done with A=0x07, B=0x05, Sub=1 -> second op starts immediately; Sum=0x02, Cout=1.
  - Sum stays 0xFE until the second completion.
- Start ignored while busy (WIDTH=8): accept A=0x10, B=0x20; at cycle 4 assert Start with A=0xFF, B=0xFF -> result Sum=0x30; exactly one Done pulse.
- Reset mid-operation (WIDTH=32): accept A=0xFFFFFFFF, B=0x1; drop rst_n at cycle 10 -> Busy=0 and all outputs clear immediately. A new Start with A=3, B=4 then gives Sum=7 after 33 edges.
